// File: rtl/ex_mem_pkg.sv
// Shared types for the EX-to-MEM pipeline register: payload layout, occupancy states, default widths.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ex_mem_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] ALUResult;
        logic [DATA_W_DEF-1:0] StoreData;
        logic [REG_W_DEF-1:0]  rd;
        logic                  RegWrite;
        logic                  VRegWrite;
        logic                  MemWrite;
        logic                  MemToReg;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_skid_reg.sv
// EX-to-MEM pipeline register built as a 2-entry skid buffer with registered ex_ready and synchronous flush.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] EX_ALUResult,
    input  logic [DATA_W-1:0] EX_StoreData,
    input  logic [REG_W-1:0]  EX_rd,
    input  logic              EX_RegWrite,
    input  logic              EX_VRegWrite,
    input  logic              EX_MemWrite,
    input  logic              EX_MemToReg,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] MEM_ALUResult,
    output logic [DATA_W-1:0] MEM_StoreData,
    output logic [REG_W-1:0]  MEM_rd,
    output logic              MEM_RegWrite,
    output logic              MEM_VRegWrite,
    output logic              MEM_MemWrite,
    output logic              MEM_MemToReg,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Local payload layout follows the instance widths rather than the package defaults.
    typedef struct packed {
        logic [DATA_W-1:0] ALUResult;
        logic [DATA_W-1:0] StoreData;
        logic [REG_W-1:0]  rd;
        logic              RegWrite;
        logic              VRegWrite;
        logic              MemWrite;
        logic              MemToReg;
    } payload_t;

    ex_mem_state_t state_q, state_d;
    payload_t      main_q, main_d;
    payload_t      skid_q, skid_d;
    payload_t      ex_pl;
    logic          ex_ready_q;
    logic          in_xfer;
    logic          out_xfer;

    assign ex_pl = '{ALUResult: EX_ALUResult, StoreData: EX_StoreData, rd: EX_rd,
                     RegWrite: EX_RegWrite, VRegWrite: EX_VRegWrite,
                     MemWrite: EX_MemWrite, MemToReg: EX_MemToReg};

    assign mem_valid = (state_q != EMPTY);
    assign in_xfer   = ex_valid & ex_ready_q;
    assign out_xfer  = mem_valid & mem_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = ex_pl;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = ex_pl;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_d  = ex_pl;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ex_ready is registered from the next state, so it drops exactly while both slots are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            ex_ready_q <= (state_d != TWO);
        end
    end

    assign ex_ready      = ex_ready_q;
    assign MEM_ALUResult = main_q.ALUResult;
    assign MEM_StoreData = main_q.StoreData;
    assign MEM_rd        = main_q.rd;
    assign MEM_MemToReg  = main_q.MemToReg;

    // Stale slot data after a flush is harmless because every side-effecting enable is gated here.
    assign MEM_RegWrite  = main_q.RegWrite  & mem_valid;
    assign MEM_VRegWrite = main_q.VRegWrite & mem_valid;
    assign MEM_MemWrite  = main_q.MemWrite  & mem_valid;

    assign fwd_valid = mem_valid & MEM_RegWrite;
    assign fwd_rd    = main_q.rd;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (mem_valid && !mem_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: queue-based occupancy model compared every cycle, plus directed literal checks.
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] EX_ALUResult;
    logic [31:0] EX_StoreData;
    logic [4:0]  EX_rd;
    logic        EX_RegWrite;
    logic        EX_VRegWrite;
    logic        EX_MemWrite;
    logic        EX_MemToReg;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_StoreData;
    logic [4:0]  MEM_rd;
    logic        MEM_RegWrite;
    logic        MEM_VRegWrite;
    logic        MEM_MemWrite;
    logic        MEM_MemToReg;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        vrw;
        logic        mw;
        logic        m2r;
    } pl_t;

    pl_t         q[$];
    logic [31:0] stallModel;
    int          checks   = 0;
    int          failures = 0;
    logic        inX;
    logic        outX;

    ex_mem_skid_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .EX_ALUResult (EX_ALUResult),
        .EX_StoreData (EX_StoreData),
        .EX_rd        (EX_rd),
        .EX_RegWrite  (EX_RegWrite),
        .EX_VRegWrite (EX_VRegWrite),
        .EX_MemWrite  (EX_MemWrite),
        .EX_MemToReg  (EX_MemToReg),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .MEM_ALUResult(MEM_ALUResult),
        .MEM_StoreData(MEM_StoreData),
        .MEM_rd       (MEM_rd),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_VRegWrite(MEM_VRegWrite),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemToReg (MEM_MemToReg),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model is a plain FIFO of accepted payloads holding at most two entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            stallModel = 32'd0;
        end else begin
            inX  = ex_valid && (q.size() < 2);
            outX = (q.size() > 0) && mem_ready;
            if ((q.size() > 0) && !mem_ready && (stallModel != 32'hFFFF_FFFF))
                stallModel = stallModel + 32'd1;
            if (flush) begin
                q.delete();
            end else begin
                if (outX) void'(q.pop_front());
                if (inX) q.push_back('{EX_ALUResult, EX_StoreData, EX_rd, EX_RegWrite,
                                       EX_VRegWrite, EX_MemWrite, EX_MemToReg});
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("mem_valid", {63'd0, mem_valid}, {63'd0, q.size() != 0});
        checkOutput("ex_ready", {63'd0, ex_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            checkOutput("MEM_ALUResult", {32'd0, MEM_ALUResult}, {32'd0, q[0].alu});
            checkOutput("MEM_StoreData", {32'd0, MEM_StoreData}, {32'd0, q[0].sd});
            checkOutput("MEM_rd", {59'd0, MEM_rd}, {59'd0, q[0].rd});
            checkOutput("MEM_RegWrite", {63'd0, MEM_RegWrite}, {63'd0, q[0].rw});
            checkOutput("MEM_VRegWrite", {63'd0, MEM_VRegWrite}, {63'd0, q[0].vrw});
            checkOutput("MEM_MemWrite", {63'd0, MEM_MemWrite}, {63'd0, q[0].mw});
            checkOutput("MEM_MemToReg", {63'd0, MEM_MemToReg}, {63'd0, q[0].m2r});
            checkOutput("fwd_valid", {63'd0, fwd_valid}, {63'd0, q[0].rw});
            checkOutput("fwd_rd", {59'd0, fwd_rd}, {59'd0, q[0].rd});
        end else begin
            checkOutput("gated_enables", {60'd0, MEM_RegWrite, MEM_VRegWrite, MEM_MemWrite, fwd_valid}, 64'd0);
        end
`ifdef EX_MEM_STALL_CNT_EN
        checkOutput("stall_cnt", {32'd0, stall_cnt}, {32'd0, stallModel});
`endif
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rdy, input logic fl,
                                 input logic [31:0] alu, input logic [4:0] rd,
                                 input logic rw, input logic vrw);
        ex_valid     = v;
        mem_ready    = rdy;
        flush        = fl;
        EX_ALUResult = alu;
        EX_StoreData = ~alu;
        EX_rd        = rd;
        EX_RegWrite  = rw;
        EX_VRegWrite = vrw;
        EX_MemWrite  = alu[0];
        EX_MemToReg  = alu[1];
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 5'd3, 1'b1, 1'b0);
        cyc();
        cyc();
        checkOutput("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("rst_MEM_RegWrite", {63'd0, MEM_RegWrite}, 64'd0);
        checkOutput("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
        checkOutput("rst_MEM_ALUResult", {32'd0, MEM_ALUResult}, 64'd0);
        checkOutput("rst_fwd", {58'd0, fwd_valid, fwd_rd}, 64'd0);
        rst_n = 1'b1;
        cyc();
        checkOutput("first_latency_valid", {63'd0, mem_valid}, 64'd1);
        checkOutput("first_latency_data", {32'd0, MEM_ALUResult}, 64'h55);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc();
        checkOutput("drain_empty", {63'd0, mem_valid}, 64'd0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, k, 5'd1, 1'b1, 1'b0);
            cyc();
            checkOutput("stream_data", {32'd0, MEM_ALUResult}, k);
            checkOutput("stream_ready", {63'd0, ex_ready}, 64'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc();

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 5'd2, 1'b1, 1'b0);
        cyc();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, 5'd4, 1'b1, 1'b0);
        cyc();
        checkOutput("two_ex_ready", {63'd0, ex_ready}, 64'd0);
        checkOutput("two_hold_a", {32'd0, MEM_ALUResult}, 64'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h99, 5'd4, 1'b1, 1'b0);
        cyc();
        checkOutput("two_still_a", {32'd0, MEM_ALUResult}, 64'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc();
        checkOutput("deliver_b", {32'd0, MEM_ALUResult}, 64'h20);
        cyc();
        checkOutput("deliver_done", {63'd0, mem_valid}, 64'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 5'd5, 1'b1, 1'b0);
        cyc();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, 5'd6, 1'b1, 1'b0);
        cyc();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        checkOutput("flush_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("flush_fwd", {63'd0, fwd_valid}, 64'd0);
        checkOutput("flush_ready", {63'd0, ex_ready}, 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h50, 5'd8, 1'b1, 1'b0);
        cyc();
        checkOutput("flush_drops_in", {63'd0, mem_valid}, 64'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h60, 5'd7, 1'b1, 1'b0);
        cyc();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        checkOutput("fwd_valid_rw", {63'd0, fwd_valid}, 64'd1);
        checkOutput("fwd_rd_7", {59'd0, fwd_rd}, 64'd7);
        mem_ready = 1'b1;
        cyc();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h70, 5'd9, 1'b0, 1'b1);
        cyc();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        checkOutput("fwd_valid_vrw", {63'd0, fwd_valid}, 64'd0);
        checkOutput("vregwrite_out", {63'd0, MEM_VRegWrite}, 64'd1);
        mem_ready = 1'b1;
        cyc();

`ifdef EX_MEM_STALL_CNT_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checkOutput("stall_after_rst", {32'd0, stall_cnt}, 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h80, 5'd1, 1'b0, 1'b0);
        cyc();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (5) cyc();
        checkOutput("stall_five", {32'd0, stall_cnt}, 64'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc();
        flush = 1'b0;
        checkOutput("stall_kept_flush", {32'd0, stall_cnt}, 64'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("stall_cleared_rst", {32'd0, stall_cnt}, 64'd0);
        cyc();
        rst_n = 1'b1;
`endif

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h90, 5'd10, 1'b1, 1'b0);
        cyc();
        EX_ALUResult = 32'hA0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {63'd0, mem_valid}, 64'd0);
        checkOutput("midrst_ready", {63'd0, ex_ready}, 64'd1);
        cyc();
        rst_n = 1'b1;

        // Random traffic with occasional flushes exercises every occupancy transition.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, $urandom, 5'($urandom),
                          1'($urandom), 1'($urandom));
            EX_StoreData = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX-to-MEM pipeline register: the consuming end of the execute stage.
- Accepts EX results plus control on a valid/ready handshake and presents them to MEM on a second valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered, back-pressure-safe ex_ready.
- Supports synchronous flush for branch/exception squash.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, register index width (rd)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
ex_valid  in  1  EX presents a valid result
ex_ready  out  1  block can accept an EX result this cycle (registered)
EX_ALUResult  in  DATA_W  ALU result / memory address
EX_StoreData  in  DATA_W  rs2 data for stores
EX_rd  in  REG_W  destination register
EX_RegWrite  in  1  scalar writeback enable
EX_VRegWrite  in  1  vector writeback enable
EX_MemWrite  in  1  store enable
EX_MemToReg  in  1  writeback source select
mem_valid  out  1  MEM_* outputs hold a valid entry
mem_ready  in  1  MEM consumes the entry this cycle
MEM_ALUResult  out  DATA_W  registered
MEM_StoreData  out  DATA_W  registered
MEM_rd  out  REG_W  registered
MEM_RegWrite  out  1  registered, gated: 0 when mem_valid=0
MEM_VRegWrite  out  1  registered, gated: 0 when mem_valid=0
MEM_MemWrite  out  1  registered, gated: 0 when mem_valid=0
MEM_MemToReg  out  1  registered
fwd_valid  out  1  mem_valid & MEM_RegWrite, for the forwarding unit
fwd_rd  out  REG_W  equals MEM_rd

Behaviour:
- Handshake definitions:
  - Input transfer: in_xfer = ex_valid & ex_ready.
  - Output transfer: out_xfer = mem_valid & mem_ready.
  - ex_valid may be held or dropped freely.
  - EX payload is sampled only on in_xfer.
  - MEM outputs are stable while mem_valid=1 and mem_ready=0.
- Storage: main slot (drives the MEM_* outputs) and skid slot.
- States: EMPTY (no valid slot), ONE (main valid), TWO (main and skid valid).
- State transitions:
  - EMPTY: in_xfer -> ONE, main<=EX. Otherwise stay.
  - ONE, in_xfer & out_xfer -> ONE, main<=EX.
  - ONE, in_xfer & !out_xfer -> TWO, skid<=EX.
  - ONE, !in_xfer & out_xfer -> EMPTY.
  - ONE, neither -> hold.
  - TWO: in_xfer is impossible (ex_ready=0). out_xfer -> ONE, main<=skid. Otherwise hold.
- ex_ready = registered (next_state != TWO). Deasserted exactly in TWO.
- mem_valid = (state != EMPTY).
- Latency: one clock from in_xfer to mem_valid when EMPTY.
- Throughput: one entry per clock when mem_ready is held high.
- Strict FIFO ordering. No drop, no duplication.
- Flush:
  - Takes priority over all transfers in the same cycle.
  - Next state EMPTY, mem_valid=0, ex_ready=1.
  - An in_xfer in the flush cycle is discarded.
  - Slot data contents are don't-care after flush; the gated write enables guarantee no side effects.
- Reset (asynchronous assert, synchronous release):
  - State EMPTY.
  - All MEM_* outputs and fwd_* outputs 0.
  - mem_valid=0, ex_ready=1.
  - Reset mid-operation discards all held entries.
- Write enables (RegWrite, VRegWrite, MemWrite) are never observed 1 with mem_valid=0.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0].
  - Increments each cycle mem_valid=1 & mem_ready=0, saturating at 32'hFFFF_FFFF.
  - Cleared by reset only, not by flush.
- When undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package ex_mem_pkg:
  - Typedef ex_mem_payload_t: struct of ALUResult, StoreData, rd, RegWrite, VRegWrite, MemWrite, MemToReg.
  - Enum ex_mem_state_t {EMPTY, ONE, TWO}.
  - Localparams DATA_W_DEF=32, REG_W_DEF=5.
- No sub-module. Both slots are plain payload_t registers inside this block.

Test Plan:
- Reset with ex_valid=1, EX_RegWrite=1 during rst_n=0 -> mem_valid=0, MEM_RegWrite=0, ex_ready=1. After release, first in_xfer appears on MEM one clock later.
- Stream ALUResult 1..8, mem_ready=1 constantly -> mem_valid continuous from cycle 1, outputs 1..8 in order, ex_ready never 0.
- Send A=0x10, B=0x20 with mem_ready=0 -> state TWO, ex_ready=0 after B, MEM_ALUResult holds 0x10. Raise mem_ready -> 0x10 then 0x20 delivered, no loss.
- In TWO, pulse flush together with mem_ready=1 -> next cycle mem_valid=0, fwd_valid=0, ex_ready=1. Neither entry ever seen with mem_ready high after flush.
- Entry rd=7, RegWrite=1 held with mem_ready=0 -> fwd_valid=1, fwd_rd=7. With MEM_VRegWrite=1, RegWrite=0 -> fwd_valid=0.
- With EX_MEM_STALL_CNT_EN defined: hold mem_valid=1, mem_ready=0 for 5 cycles -> stall_cnt=5. Flush -> stall_cnt stays 5. Reset -> 0.
